// File: rtl/lenet_pkg.sv
// Shared types for the LeNet-style streaming layers: sample width default,
// pooling mode and pooling FSM state encodings.
package lenet_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pool_state_e;

endpackage

// File: rtl/pool_lane.sv
// One channel of the 2x2 pooling datapath: horizontal pair register, line
// buffer of pair results from the even row, window combine and optional ReLU.
module pool_lane
  import lenet_pkg::*;
#(
  parameter int MAPSIZE = 28,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int IDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic              col_odd,
  input  logic              row_odd,
  input  logic [IDX_W-1:0]  lb_idx,
  input  pool_mode_e        pool_mode,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] result
);

  localparam int ENTRIES = MAPSIZE / 2;

  logic signed [DATA_W-1:0] cur;
  logic signed [DATA_W-1:0] pair_q;
  logic signed [DATA_W:0]   pair_val;
  logic signed [DATA_W:0]   lb_val;
  logic signed [DATA_W:0]   win_max;
  logic signed [DATA_W+1:0] win_sum;
  logic signed [DATA_W-1:0] pooled;
  logic signed [DATA_W-1:0] win_out;
  logic signed [DATA_W:0]   lb_mem [ENTRIES];

  assign cur    = sample;
  assign lb_val = lb_mem[lb_idx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pair_val = '0;
    win_max  = '0;
    win_sum  = '0;
    pooled   = '0;
    win_out  = '0;
    if (pool_mode == POOL_MAX) begin
      pair_val = (cur > pair_q) ? {cur[DATA_W-1], cur} : {pair_q[DATA_W-1], pair_q};
    end else begin
      pair_val = {pair_q[DATA_W-1], pair_q} + {cur[DATA_W-1], cur};
    end
    win_max = (pair_val > lb_val) ? pair_val : lb_val;
    win_sum = {lb_val[DATA_W], lb_val} + {pair_val[DATA_W], pair_val};
    // Dropping the two LSBs of the signed sum is the floor of sum/4.
    pooled  = (pool_mode == POOL_MAX) ? win_max[DATA_W-1:0] : win_sum[DATA_W+1:2];
    win_out = (relu_en && pooled[DATA_W-1]) ? '0 : pooled;
  end

  // NOTE: the line buffer has no reset; every entry is rewritten on an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) begin
      lb_mem[lb_idx] <= pair_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
      result <= '0;
    end else begin
      if (clear) begin
        pair_q <= '0;
      end else if (accept && !col_odd) begin
        pair_q <= cur;
      end
      if (accept && col_odd && row_odd) begin
        result <= win_out;
      end
    end
  end

endmodule

// File: rtl/pool_stream_mc.sv
// Streaming multi-channel 2x2/stride-2 max or average pooling over a raster
// feature map; raster counters and frame FSM shared by all channel lanes.
module pool_stream_mc
  import lenet_pkg::*;
#(
  parameter int MAPSIZE  = 28,
  parameter int CHANNELS = 6,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       pool_mode,
  input  logic                       relu_en,
  input  logic                       data_valid_in,
  input  logic [CHANNELS*DATA_W-1:0] pixel_in,
  output logic                       data_valid_out,
  output logic [CHANNELS*DATA_W-1:0] pixel_out,
  output logic                       layer_done,
  output logic                       busy
);

  localparam int CNT_W = $clog2(MAPSIZE);
  localparam int IDX_W = (MAPSIZE > 2) ? $clog2(MAPSIZE / 2) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAPSIZE - 1);

  if (MAPSIZE < 2 || (MAPSIZE % 2) != 0) begin : g_bad_mapsize
    $error("pool_stream_mc: MAPSIZE must be even and >= 2");
  end

  pool_state_e      state;
  pool_mode_e       mode_q;
  logic             relu_q;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;
  logic             accept;
  logic             emit;
  logic             last_px;
  logic [IDX_W-1:0] lb_idx;

  // A start pulse always wins over a coincident pixel.
  assign accept  = (state == RUN) && data_valid_in && !start;
  assign emit    = accept && row[0] && col[0];
  assign last_px = (row == LAST) && (col == LAST);
  assign lb_idx  = IDX_W'(col >> 1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      row            <= '0;
      col            <= '0;
      mode_q         <= POOL_MAX;
      relu_q         <= 1'b0;
      data_valid_out <= 1'b0;
      layer_done     <= 1'b0;
    end else begin
      data_valid_out <= emit;
      layer_done     <= emit && last_px;
      if (start) begin
        state  <= RUN;
        busy   <= 1'b1;
        row    <= '0;
        col    <= '0;
        mode_q <= pool_mode_e'(pool_mode);
        relu_q <= relu_en;
      end else if (accept) begin
        if (col == LAST) begin
          col <= '0;
          if (row == LAST) begin
            row   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_lane #(
      .MAPSIZE(MAPSIZE),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (start),
      .accept   (accept),
      .col_odd  (col[0]),
      .row_odd  (row[0]),
      .lb_idx   (lb_idx),
      .pool_mode(mode_q),
      .relu_en  (relu_q),
      .sample   (pixel_in[c*DATA_W +: DATA_W]),
      .result   (pixel_out[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_pool_stream_mc.sv
// Scoreboard bench for pool_stream_mc at MAPSIZE=4, CHANNELS=2, DATA_W=8:
// a window-level reference model queues expected outputs, a monitor checks them.
module tb_pool_stream_mc;

  localparam int MS = 4;
  localparam int CH = 2;
  localparam int DW = 8;
  localparam int NPX = MS * MS;

  typedef struct {
    logic [CH*DW-1:0] px;
    bit               done;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             pool_mode;
  logic             relu_en;
  logic             data_valid_in;
  logic [CH*DW-1:0] pixel_in;
  logic             data_valid_out;
  logic [CH*DW-1:0] pixel_out;
  logic             layer_done;
  logic             busy;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  exp_t             exp_q[$];
  logic [CH*DW-1:0] frame_px[NPX];
  logic [CH*DW-1:0] img[NPX];
  logic [CH*DW-1:0] last_out = '0;
  bit               tb_run = 0;
  bit               m_mode = 0;
  bit               m_relu = 0;
  int               k = 0;

  pool_stream_mc #(.MAPSIZE(MS), .CHANNELS(CH), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pool_mode     (pool_mode),
    .relu_en       (relu_en),
    .data_valid_in (data_valid_in),
    .pixel_in      (pixel_in),
    .data_valid_out(data_valid_out),
    .pixel_out     (pixel_out),
    .layer_done    (layer_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int floor_div4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  // Reference: pooled value of window (wr, wc) from the accepted image.
  function automatic logic [CH*DW-1:0] window(input int wr, input int wc);
    logic [CH*DW-1:0] res;
    logic [CH*DW-1:0] p;
    int best, sum, v, r;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      best = -100000;
      sum  = 0;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          p = img[(2 * wr + dr) * MS + 2 * wc + dc];
          v = int'($signed(p[ch*DW +: DW]));
          sum += v;
          if (v > best) best = v;
        end
      end
      r = m_mode ? floor_div4(sum) : best;
      if (m_relu && r < 0) r = 0;
      res[ch*DW +: DW] = DW'(r);
    end
    return res;
  endfunction

  // One clock of stimulus; afterwards the model mirrors what the frame rules say was accepted.
  task automatic step(input bit v, input logic [CH*DW-1:0] px, input bit st);
    int r, c;
    data_valid_in = v;
    pixel_in      = px;
    start         = st;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      tb_run = 0;
    end else if (st) begin
      tb_run = 1;
      k      = 0;
      m_mode = pool_mode;
      m_relu = relu_en;
    end else if (v && tb_run) begin
      img[k] = px;
      r = k / MS;
      c = k % MS;
      if ((r % 2) == 1 && (c % 2) == 1) begin
        exp_q.push_back('{px: window(r / 2, c / 2), done: (k == NPX - 1), due: cyc});
      end
      k++;
      if (k == NPX) tb_run = 0;
    end
    data_valid_in = 1'b0;
    start         = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 every other cycle plus random extra gaps, 2 random gaps.
  task automatic run_frame(input int n_px, input int gap_mode, input bit mode, input bit relu,
                           input bit start_with_valid);
    int gaps;
    pool_mode = mode;
    relu_en   = relu;
    step(start_with_valid, CH*DW'($urandom), 1'b1);
    pool_mode = 1'($urandom);
    relu_en   = 1'($urandom);
    for (int i = 0; i < n_px; i++) begin
      gaps = (gap_mode == 1) ? 1 + $urandom_range(0, 2) : (gap_mode == 2) ? $urandom_range(0, 3) : 0;
      for (int g = 0; g < gaps; g++) step(1'b0, CH*DW'($urandom), 1'b0);
      step(1'b1, frame_px[i], 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) step(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    tb_run   = 0;
    last_out = '0;
    exp_q.delete();
    repeat (2) step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_valid", 32'(data_valid_out), 32'd0);
      check("rst_done", 32'(layer_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pixel", 32'(pixel_out), 32'd0);
    end else begin
      check("busy", 32'(busy), 32'(tb_run));
      if (data_valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(data_valid_out), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'(pixel_out), 32'(e.px));
          check("layer_done", 32'(layer_done), 32'(e.done));
          check("latency", 32'(cyc), 32'(e.due));
          last_out = e.px;
        end
      end else begin
        check("hold", 32'(pixel_out), 32'(last_out));
        if (layer_done) check("done_no_valid", 32'(layer_done), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    pool_mode     = 1'b0;
    relu_en       = 1'b0;
    data_valid_in = 1'b0;
    pixel_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Valid pixels while idle are ignored.
    repeat (4) step(1'b1, CH*DW'($urandom), 1'b0);

    // Max mode ramp / constant -1.
    for (int i = 0; i < NPX; i++) frame_px[i] = {8'hFF, 8'(i)};
    run_frame(NPX, 0, 1'b0, 1'b0, 1'b0);
    drain();

    // Average mode, ch1 window {-1,-2,-2,-2}.
    for (int i = 0; i < NPX; i++) frame_px[i] = {(i == 0) ? 8'hFF : 8'hFE, 8'(i)};
    run_frame(NPX, 0, 1'b1, 1'b0, 1'b0);
    drain();

    // ReLU on and off with ch1 = -8.
    for (int i = 0; i < NPX; i++) frame_px[i] = {8'hF8, 8'(i)};
    run_frame(NPX, 0, 1'b0, 1'b1, 1'b0);
    drain();
    run_frame(NPX, 0, 1'b0, 1'b0, 1'b0);
    drain();

    // Gapped valid, same data as the first frame.
    for (int i = 0; i < NPX; i++) frame_px[i] = {8'hFF, 8'(i)};
    run_frame(NPX, 1, 1'b0, 1'b0, 1'b0);
    drain();

    // Random frames, random gaps, start coincident with valid.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NPX; i++) frame_px[i] = CH*DW'($urandom);
      run_frame(NPX, 2, 1'($urandom), 1'($urandom), 1'($urandom));
      drain();
    end

    // Abort by re-start after 6 pixels, then a full frame.
    for (int i = 0; i < NPX; i++) frame_px[i] = CH*DW'($urandom);
    run_frame(6, 0, 1'b1, 1'b0, 1'b0);
    run_frame(NPX, 0, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset after 10 pixels; pixels without a new start are ignored.
    run_frame(10, 0, 1'b1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, frame_px[i], 1'b0);
    drain();
    run_frame(NPX, 2, 1'b1, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
